// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares one single-ported memory backend between the instruction and data
//   caches of an in-order RISC-V core. Data accesses win over fetches; when
//   both are requested together they are served back to back (data, then
//   fetch) inside a single stall window, followed by a one-cycle RESP state
//   in which the core sees stall low and picks up the registered read data.
//   An access that is not acknowledged within TIMEOUT waiting cycles is
//   completed with zero read data and raises the sticky mem_err flag.
//
// Ports
//   clk, reset                synchronous active-high reset
//   icache_re / icache_addr   instruction fetch request and byte address
//   dcache_re / dcache_we     data load request / byte write enables (store)
//   dcache_addr / dcache_din  data byte address and store data
//   icache_dout, dcache_dout  registered fetch / load data
//   stall                     core must hold requests and pipeline while high
//   mem_req/we/addr/wdata     backend request (word address)
//   mem_rdata, mem_ack        backend read data and one-cycle completion pulse
//   mem_err                   sticky timeout flag, cleared only by reset
module riscv_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_re,
  input  logic [31:0] icache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_din,
  output logic [31:0] icache_dout,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_err
);

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        data_pend, inst_pend;
  logic [29:0] daddr_q, iaddr_q;   // word addresses
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic [9:0]  wait_cnt;

  logic        data_req, any_req, in_acc, timed_out, done;
  logic [31:0] rdata_eff;

  // Byte offsets never reach the backend, which is word addressed.
  logic        unused_offset;
  assign unused_offset = ^{icache_addr[1:0], dcache_addr[1:0]};

  assign data_req  = dcache_re | (|dcache_we);
  assign any_req   = data_req | icache_re;
  assign in_acc    = (state == DACC) || (state == IACC);
  // A real ack in the timeout cycle wins: normal completion, no error.
  assign timed_out = in_acc && !mem_ack && (wait_cnt == TIMEOUT_CNT);
  assign done      = in_acc && (mem_ack || timed_out);
  assign rdata_eff = mem_ack ? mem_rdata : 32'h0;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        stall = any_req;
        if (data_req)       state_nxt = DACC;
        else if (icache_re) state_nxt = IACC;
      end
      DACC: begin
        stall     = 1'b1;
        mem_req   = data_pend;  // always set while DACC is active
        mem_we    = we_q;
        mem_addr  = {daddr_q, 2'b00};
        mem_wdata = wdata_q;
        if (done) state_nxt = inst_pend ? IACC : RESP;
      end
      IACC: begin
        stall    = 1'b1;
        mem_req  = inst_pend;   // always set while IACC is active
        mem_addr = {iaddr_q, 2'b00};
        if (done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_pend   <= 1'b0;
      inst_pend   <= 1'b0;
      wait_cnt    <= 10'd0;
      mem_err     <= 1'b0;
      icache_dout <= 32'h0;
      dcache_dout <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        data_pend <= data_req;
        inst_pend <= icache_re;
      end
      // Restart on completion so a DACC->IACC hand-off begins at zero.
      if (in_acc && !done) wait_cnt <= wait_cnt + 10'd1;
      else                 wait_cnt <= 10'd0;
      if (timed_out) mem_err <= 1'b1;
      if (state == DACC && done && we_q == 4'b0000) dcache_dout <= rdata_eff;
      if (state == IACC && done) icache_dout <= rdata_eff;
    end
  end

  // NOTE: the captured address/data registers have no reset; they only reach
  // the bus while the matching pending bit, which is reset, is set.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      daddr_q <= dcache_addr[31:2];
      iaddr_q <= icache_addr[31:2];
      we_q    <= dcache_we;
      wdata_q <= dcache_din;
    end
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_ack on one access; legal range 1..1023.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 icache_re  in  1  instruction fetch request.
REQ-005 icache_addr  in  32  fetch byte address.
REQ-006 dcache_re  in  1  data read request.
REQ-007 dcache_we  in  4  data byte write enables; nonzero means store.
REQ-008 dcache_addr  in  32  data byte address.
REQ-009 dcache_din  in  32  store data.
REQ-010 icache_dout  out  32  registered fetch data.
REQ-011 dcache_dout  out  32  registered load data.
REQ-012 stall  out  1  core must hold all requests and pipeline state while high.
REQ-013 mem_req  out  1  backend access request.
REQ-014 mem_we  out  4  backend byte write enables.
REQ-015 mem_addr  out  32  backend word address, {addr[31:2],2'b00}.
REQ-016 mem_wdata  out  32  backend write data.
REQ-017 mem_rdata  in  32  backend read data, valid only in the mem_ack cycle.
REQ-018 mem_ack  in  1  one-cycle completion pulse from the backend.
REQ-019 mem_err  out  1  sticky timeout flag.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, DACC, IACC and RESP.
REQ-021 In IDLE, the pending set SHALL be captured into registers: data pending = dcache_re | (|dcache_we); inst pending = icache_re.
REQ-022 IDLE transitions SHALL be: data pending -> DACC; else inst pending -> IACC; else stay in IDLE.
REQ-023 In IDLE, stall SHALL equal (icache_re | dcache_re | |dcache_we), combinationally.
REQ-024 stall SHALL be 1 in DACC and IACC, and 0 in RESP.
REQ-025 Data SHALL have priority over instruction; a simultaneous data and inst request SHALL be served as DACC then IACC within one stall window.
REQ-026 In DACC and IACC, mem_req SHALL be 1, with mem_addr, mem_we and mem_wdata stable from the captured values until mem_ack.
REQ-027 In IACC, mem_we SHALL be 4'b0000.
REQ-028 In all other states, mem_req, mem_we and mem_wdata SHALL be 0.
REQ-029 A DACC load completion SHALL register mem_rdata into dcache_dout.
REQ-030 A DACC store completion SHALL leave dcache_dout unchanged.
REQ-031 DACC completion SHALL go to IACC if inst pending, else to RESP.
REQ-032 IACC completion SHALL register mem_rdata into icache_dout and go to RESP.
REQ-033 RESP SHALL last exactly one cycle, then go to IDLE; minimum latency from request to stall low is 3 cycles for a single access with immediate ack.
REQ-034 A wait counter SHALL reset to 0 on entry to DACC or IACC and increment each cycle without mem_ack.
REQ-035 When the wait counter reaches TIMEOUT, the access SHALL complete as if acked with mem_rdata forced to 0, and mem_err SHALL set to 1.
REQ-036 mem_err SHALL clear only on reset.
REQ-037 mem_ack outside DACC and IACC SHALL be ignored.
REQ-038 mem_ack coincident with the timeout cycle SHALL be treated as a normal ack, with mem_err unchanged.
REQ-039 Requests arriving in RESP SHALL be ignored until IDLE.

Reset
REQ-040 On reset, the FSM SHALL go to IDLE, and icache_dout, dcache_dout, the wait counter, mem_err and the pending registers SHALL be 0.
REQ-041 Reset asserted mid-access SHALL force mem_req to 0 from the next cycle and discard the in-flight access; a late mem_ack SHALL be ignored.
REQ-042 After reset, stall SHALL follow REQ-023.

Verification
REQ-043 Fetch only: icache_re=1, icache_addr=0x2004, ack on the first DACC/IACC cycle with rdata 0x00500093 -> mem_addr=0x2004; icache_dout=0x00500093 in RESP; stall high for exactly 2 cycles.
REQ-044 Load plus fetch: dcache_re=1 at 0x1002, icache_addr=0x2008 -> data access first at mem_addr=0x1000, then fetch at 0x2008; stall low only in RESP; both douts updated.
REQ-045 Store: dcache_we=4'b0011, dcache_din=0xBEEF, backend ack delayed 5 cycles -> mem_we=0011 and mem_wdata=0xBEEF held for 6 cycles; dcache_dout unchanged.
REQ-046 Timeout: TIMEOUT=4, no ack -> access ends after 4 waiting cycles; mem_err=1; icache_dout=0; mem_err stays 1 until reset.
REQ-047 Reset in the third cycle of DACC -> mem_req=0 the next cycle; a mem_ack two cycles later leaves outputs 0; FSM in IDLE.
REQ-048 Idle: all requests 0 for 10 cycles -> stall=0 and mem_req=0 throughout.
